// File: rtl/alu_issue_stage.sv
// Issue stage feeding a combinational ALU: owns the register file, registers operands, writes back and presents results.
// Optional ALU_TRAP_ILLEGAL_EN: op codes 100/110/111 are flagged on out_illegal, zeroed and not written back.
module alu_issue_stage #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AW-1:0]    in_rd,
    input  logic [AW-1:0]    in_rs1,
    input  logic [AW-1:0]    in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_use_imm,
    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             Zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_rd,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
`ifdef ALU_TRAP_ILLEGAL_EN
    output logic             out_illegal,
`endif
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] srca_q, srca_d;
    logic [WIDTH-1:0] srcb_q, srcb_d;
    logic [2:0]       op_q, op_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic             trap_q, trap_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [AW-1:0]    out_rd_q, out_rd_d;
    logic             out_zero_q, out_zero_d;
    logic             out_valid_q, out_valid_d;
`ifdef ALU_TRAP_ILLEGAL_EN
    logic             out_illegal_q, out_illegal_d;
`endif
    logic [WIDTH-1:0] regs_q [NREGS];
    logic             latch_op;
    logic             wr_en;
    logic             op_is_trap;

`ifdef ALU_TRAP_ILLEGAL_EN
    assign op_is_trap = (in_op == 3'b100) || (in_op == 3'b110) || (in_op == 3'b111);
`else
    assign op_is_trap = 1'b0;
`endif

    // A pending result blocks new ops until downstream takes it.
    assign in_ready = (state_q == IDLE) || ((state_q == WB) && out_ready);

    always_comb begin
        state_d      = state_q;
        srca_d       = srca_q;
        srcb_d       = srcb_q;
        op_d         = op_q;
        rd_d         = rd_q;
        trap_d       = trap_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        out_zero_d   = out_zero_q;
        out_valid_d  = out_valid_q;
`ifdef ALU_TRAP_ILLEGAL_EN
        out_illegal_d = out_illegal_q;
`endif
        latch_op = 1'b0;
        wr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    latch_op = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                state_d      = WB;
                out_valid_d  = 1'b1;
                out_rd_d     = rd_q;
                out_result_d = trap_q ? '0 : ALUResult;
                out_zero_d   = trap_q ? 1'b0 : Zero;
`ifdef ALU_TRAP_ILLEGAL_EN
                out_illegal_d = trap_q;
`endif
                wr_en        = !trap_q && (rd_q != '0);
            end
            WB: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        latch_op = 1'b1;
                        state_d  = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // x0 is never written, so indexing it yields zero without a special case.
        if (latch_op) begin
            srca_d = regs_q[in_rs1];
            srcb_d = in_use_imm ? in_imm : regs_q[in_rs2];
            op_d   = in_op;
            rd_d   = in_rd;
            trap_d = op_is_trap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            srca_q       <= '0;
            srcb_q       <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            trap_q       <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_zero_q   <= 1'b0;
            out_valid_q  <= 1'b0;
`ifdef ALU_TRAP_ILLEGAL_EN
            out_illegal_q <= 1'b0;
`endif
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            srca_q       <= srca_d;
            srcb_q       <= srcb_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            trap_q       <= trap_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_zero_q   <= out_zero_d;
            out_valid_q  <= out_valid_d;
`ifdef ALU_TRAP_ILLEGAL_EN
            out_illegal_q <= out_illegal_d;
`endif
            if (wr_en) begin
                regs_q[rd_q] <= ALUResult;
            end
        end
    end

    assign SrcA       = srca_q;
    assign SrcB       = srcb_q;
    assign ALUControl = op_q;
    assign out_valid  = out_valid_q;
    assign out_rd     = out_rd_q;
    assign out_result = out_result_q;
    assign out_zero   = out_zero_q;
`ifdef ALU_TRAP_ILLEGAL_EN
    assign out_illegal = out_illegal_q;
`endif
    assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: acts as the ALU, keeps a transaction-level model checked every cycle, plus directed literals.
module tb_alu_issue_stage;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [AW-1:0]    in_rd;
    logic [AW-1:0]    in_rs1;
    logic [AW-1:0]    in_rs2;
    logic [WIDTH-1:0] in_imm;
    logic             in_use_imm;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_rd;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
`ifdef ALU_TRAP_ILLEGAL_EN
    logic             out_illegal;
`endif
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_use_imm(in_use_imm),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .ALUResult(ALUResult), .Zero(Zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_result(out_result), .out_zero(out_zero),
`ifdef ALU_TRAP_ILLEGAL_EN
        .out_illegal(out_illegal),
`endif
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [2:0] op);
        case (op)
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic bit trap_f(input logic [2:0] op);
`ifdef ALU_TRAP_ILLEGAL_EN
        return (op == 3'b100) || (op == 3'b110) || (op == 3'b111);
`else
        return 1'b0;
`endif
    endfunction

    // Environment ALU driven from the DUT's registered operands.
    always_comb begin
        ALUResult = alu_f(SrcA, SrcB, ALUControl);
        Zero      = (ALUResult == '0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 = nothing in flight, 1 = op issued, 2 = result pending.
    bit               m_on = 1'b0;
    int               m_phase = 0;
    logic [WIDTH-1:0] m_reg [NREGS];
    logic [WIDTH-1:0] m_a, m_b, m_res;
    logic [2:0]       m_op;
    logic [AW-1:0]    m_rd, m_out_rd;
    logic             m_zero, m_ill, m_trap;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_on = 1'b1; m_phase = 0;
            m_a = '0; m_b = '0; m_op = '0; m_rd = '0; m_trap = 1'b0;
            m_res = '0; m_out_rd = '0; m_zero = 1'b0; m_ill = 1'b0;
            for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
        end else if (m_on) begin
            if (m_phase == 1) begin
                logic [WIDTH-1:0] r;
                r = alu_f(m_a, m_b, m_op);
                if (!m_trap && m_rd != 0) m_reg[m_rd] = r;
                m_res    = m_trap ? '0 : r;
                m_zero   = m_trap ? 1'b0 : (r == '0);
                m_ill    = m_trap;
                m_out_rd = m_rd;
                m_phase  = 2;
            end else if (in_valid && (m_phase == 0 || out_ready)) begin
                m_a     = m_reg[in_rs1];
                m_b     = in_use_imm ? in_imm : m_reg[in_rs2];
                m_op    = in_op;
                m_rd    = in_rd;
                m_trap  = trap_f(in_op);
                m_phase = 1;
            end else if (m_phase == 2 && out_ready) begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, (m_phase == 0) || (m_phase == 2 && out_ready)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
            chk("SrcA", {16'd0, SrcA}, {16'd0, m_a});
            chk("SrcB", {16'd0, SrcB}, {16'd0, m_b});
            chk("ALUControl", {29'd0, ALUControl}, {29'd0, m_op});
            chk("out_rd", {29'd0, out_rd}, {29'd0, m_out_rd});
            chk("out_result", {16'd0, out_result}, {16'd0, m_res});
            chk("out_zero", {31'd0, out_zero}, {31'd0, m_zero});
`ifdef ALU_TRAP_ILLEGAL_EN
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, m_ill});
`endif
            chk("dbg_data", {16'd0, dbg_data}, {16'd0, m_reg[dbg_addr]});
        end
    end

    task automatic issue(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                         input logic [WIDTH-1:0] imm, input logic use_imm);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; in_op = op; in_rd = AW'(rd); in_rs1 = AW'(rs1); in_rs2 = AW'(rs2);
        in_imm = imm; in_use_imm = use_imm;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("issue_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [WIDTH-1:0] exp, input logic exp_zero);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk({name, "_seen"}, {31'd0, seen}, 32'd1);
        chk(name, {16'd0, out_result}, {16'd0, exp});
        chk({name, "_zero"}, {31'd0, out_zero}, {31'd0, exp_zero});
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string name, input int addr, input logic [WIDTH-1:0] exp);
        dbg_addr = AW'(addr);
        @(negedge clk);
        chk(name, {16'd0, dbg_data}, {16'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; in_use_imm = 1'b0; out_ready = 1'b0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", {16'd0, out_result}, 32'd0);
        chk("rst_SrcA", {16'd0, SrcA}, 32'd0);
        @(posedge clk);
        #1;
        for (int a = 0; a < NREGS; a++) peek("rst_dbg", a, 16'h0000);

        out_ready = 1'b1;
        $display("txn ADD imm: R1 = x0 + 5");
        issue(3'b000, 1, 0, 0, 16'h0005, 1'b1);
        wait_result("add1", 16'h0005, 1'b0);
        $display("txn ADD imm dependent: R2 = R1 + 3");
        issue(3'b000, 2, 1, 0, 16'h0003, 1'b1);
        wait_result("add2", 16'h0008, 1'b0);
        peek("add2_R2", 2, 16'h0008);

        $display("txn SUB zero: R3 = R1 - R2 with R1=R2=5");
        issue(3'b000, 2, 1, 0, 16'h0000, 1'b1);
        wait_result("set_r2", 16'h0005, 1'b0);
        issue(3'b001, 3, 1, 2, 16'h0000, 1'b0);
        wait_result("sub_zero", 16'h0000, 1'b1);
        $display("txn SUB wrap: R4 = 0 - 1");
        issue(3'b000, 1, 0, 0, 16'h0000, 1'b1);
        wait_result("set_r1", 16'h0000, 1'b1);
        issue(3'b000, 2, 0, 0, 16'h0001, 1'b1);
        wait_result("set_r2b", 16'h0001, 1'b0);
        issue(3'b001, 4, 1, 2, 16'h0000, 1'b0);
        wait_result("sub_wrap", 16'hFFFF, 1'b0);

        $display("txn backpressure: R5 = 0x1234 held, R6 = R5 + 1 queued");
        out_ready = 1'b0;
        issue(3'b000, 5, 0, 0, 16'h1234, 1'b1);
        in_valid = 1'b1; in_op = 3'b000; in_rd = 3'd6; in_rs1 = 3'd5; in_imm = 16'h0001; in_use_imm = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_result", {16'd0, out_result}, 32'h0000_1234);
            chk("bp_out_rd", {29'd0, out_rd}, 32'd5);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result("bp_second", 16'h1235, 1'b0);

        $display("txn OR to x0: x0 = R1 | 0x000F");
        issue(3'b000, 1, 0, 0, 16'h00F0, 1'b1);
        wait_result("set_f0", 16'h00F0, 1'b0);
        issue(3'b011, 0, 1, 0, 16'h000F, 1'b1);
        wait_result("or_x0", 16'h00FF, 1'b0);
        peek("x0_dbg", 0, 16'h0000);

        $display("txn SLT: 2 < 7 then 7 < 2");
        issue(3'b000, 1, 0, 0, 16'h0002, 1'b1);
        wait_result("set_2", 16'h0002, 1'b0);
        issue(3'b000, 2, 0, 0, 16'h0007, 1'b1);
        wait_result("set_7", 16'h0007, 1'b0);
        issue(3'b101, 3, 1, 2, 16'h0000, 1'b0);
        wait_result("slt_lt", 16'h0001, 1'b0);
        issue(3'b101, 3, 2, 1, 16'h0000, 1'b0);
        wait_result("slt_ge", 16'h0000, 1'b1);

        $display("txn op 110 on R1=2 imm 3");
        issue(3'b110, 5, 1, 0, 16'h0003, 1'b1);
`ifdef ALU_TRAP_ILLEGAL_EN
        wait_result("op110", 16'h0000, 1'b0);
        peek("op110_R5", 5, 16'h1234);
`else
        wait_result("op110", 16'h0005, 1'b0);
        peek("op110_R5", 5, 16'h0005);
`endif

        $display("txn reset during EXEC: R4 = 0x7777 aborted");
        issue(3'b000, 4, 0, 0, 16'h7777, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        peek("abort_R4", 4, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
